// File: rtl/irq_controller_pkg.sv
// Shared opcodes, bus addresses and field widths for the interrupt aggregator.
package irq_controller_pkg;

   typedef enum logic [2:0] {
      OP_MODE    = 3'd0,
      OP_ENABLE  = 3'd1,
      OP_PENDING = 3'd2,
      OP_ID      = 3'd3,
      OP_EOI     = 3'd4
   } opcode_t;

   localparam logic ADDR_CMD  = 1'b0;
   localparam logic ADDR_DATA = 1'b1;

   localparam int OPC_W  = 3;
   localparam int BANK_W = 5;
   localparam int ID_W   = 8;

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-wins priority encoder over the active interrupt vector.
module irq_priority_encoder
   import irq_controller_pkg::*;
#(
   parameter int N = 256
) (
   input  logic [N-1:0]    vec,
   output logic [ID_W-1:0] idx,
   output logic            valid
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// 256-source interrupt aggregator behind a two-location byte-wide CPU bus window.
// State advances on the falling clk edge, when the CPU bus data is valid.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int N_INT = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       i_data,
   output logic [7:0]       o_data,
   input  logic             addr,
   input  logic             cs,
   input  logic             rwb,
   input  logic [N_INT-1:0] int_in,
   output logic             int_out
);

   localparam int N_BANKS = N_INT / 8;
   localparam int IDX_W   = $clog2(N_INT);

   logic [7:0]        cmd;
   logic [N_INT-1:0]  mode, enable, latched, prev;

   logic [OPC_W-1:0]  opcode;
   logic [BANK_W-1:0] bank;
   logic [IDX_W-1:0]  base;
   logic              bank_ok;
   logic              wr_cmd, wr_data;

   logic [N_INT-1:0]  visible, active;
   logic [ID_W-1:0]   id;
   logic              id_valid;

   logic [N_INT-1:0]  mode_d, enable_d, clr, latched_d, visible_d;
   logic              int_out_d;

   assign opcode  = cmd[7:5];
   assign bank    = cmd[4:0];
   assign base    = IDX_W'({bank, 3'b000});
   assign wr_cmd  = cs && !rwb && (addr == ADDR_CMD);
   assign wr_data = cs && !rwb && (addr == ADDR_DATA);

   generate
      if (N_BANKS >= (1 << BANK_W)) begin : g_all_banks
         assign bank_ok = 1'b1;
      end else begin : g_some_banks
         assign bank_ok = (32'(bank) < N_BANKS);
      end
   endgenerate

   // Level sources expose the last sampled input; edge sources expose the latch.
   assign visible = (mode & latched) | (~mode & prev);
   assign active  = visible & enable;

   irq_priority_encoder #(.N(N_INT)) u_prio (
      .vec   (active),
      .idx   (id),
      .valid (id_valid)
   );

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      mode_d   = mode;
      enable_d = enable;
      clr      = '0;
      if (wr_data) begin
         case (opcode)
            OP_MODE:    if (bank_ok) mode_d[base +: 8]   = i_data;
            OP_ENABLE:  if (bank_ok) enable_d[base +: 8] = i_data;
            OP_PENDING: if (bank_ok) clr[base +: 8]      = i_data;
            OP_EOI:     if (id_valid && mode[id[IDX_W-1:0]]) clr[id[IDX_W-1:0]] = 1'b1;
            default:    ;
         endcase
      end
      // Clear is applied first so a simultaneous new edge still sets the bit.
      latched_d = (latched & ~clr) | (int_in & ~prev & mode);
      visible_d = (mode_d & latched_d) | (~mode_d & int_in);
      int_out_d = |(visible_d & enable_d);
   end

   // NOTE: state uses non-blocking assignments so all registers update together.
   always_ff @(negedge clk) begin
      if (reset) begin
         cmd     <= '0;
         mode    <= '0;
         enable  <= '0;
         latched <= '0;
         prev    <= '0;
         int_out <= 1'b0;
      end else begin
         if (wr_cmd) cmd <= i_data;
         mode    <= mode_d;
         enable  <= enable_d;
         latched <= latched_d;
         prev    <= int_in;
         int_out <= int_out_d;
      end
   end

   always_comb begin
      o_data = 8'h00;
      if (cs && rwb) begin
         if (addr == ADDR_CMD) begin
            o_data = cmd;
         end else begin
            case (opcode)
               OP_MODE:    if (bank_ok) o_data = mode[base +: 8];
               OP_ENABLE:  if (bank_ok) o_data = enable[base +: 8];
               OP_PENDING: if (bank_ok) o_data = visible[base +: 8];
               OP_ID:      if (id_valid) o_data = id;
               default:    o_data = 8'h00;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expected values.
module tb_irq_controller;
   import irq_controller_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   i_data = 8'h00;
   logic [7:0]   o_data;
   logic         addr = 1'b0;
   logic         cs = 1'b0;
   logic         rwb = 1'b1;
   logic [255:0] int_in = '0;
   logic         int_out;

   int checks = 0;
   int failures = 0;

   irq_controller #(.N_INT(256)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_data  (i_data),
      .o_data  (o_data),
      .addr    (addr),
      .cs      (cs),
      .rwb     (rwb),
      .int_in  (int_in),
      .int_out (int_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   // Advance past one falling (active) edge and settle.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic bus_write(input logic a, input logic [7:0] d);
      @(posedge clk);
      addr   = a;
      i_data = d;
      cs     = 1'b1;
      rwb    = 1'b0;
      @(negedge clk);
      #1;
      cs     = 1'b0;
      rwb    = 1'b1;
   endtask

   task automatic bus_read(input string tag, input logic a, input logic [7:0] exp);
      addr = a;
      cs   = 1'b1;
      rwb  = 1'b1;
      #1;
      check(tag, o_data, exp);
      cs   = 1'b0;
      #1;
   endtask

   initial begin
      // Reset and idle readback under every opcode.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_int_out", {7'b0, int_out}, 8'h00);
      check("idle_o_data", o_data, 8'h00);
      bus_read("rst_cmd", ADDR_CMD, 8'h00);
      for (int op = 0; op < 8; op++) begin
         bus_write(ADDR_CMD, 8'(op << 5));
         bus_read($sformatf("rst_data_op%0d", op), ADDR_DATA, 8'h00);
      end

      // Level source 0: int_out follows the sampled input for one cycle.
      bus_write(ADDR_CMD, 8'h10);
      bus_write(ADDR_DATA, 8'hFF);
      bus_read("mode_bank16", ADDR_DATA, 8'hFF);
      bus_write(ADDR_CMD, 8'h20);
      bus_write(ADDR_DATA, 8'hFF);
      bus_read("enable_bank0", ADDR_DATA, 8'hFF);
      bus_write(ADDR_CMD, 8'h40);
      check("lvl_pre", {7'b0, int_out}, 8'h00);
      int_in[0] = 1'b1;
      tick();
      check("lvl_int_out_hi", {7'b0, int_out}, 8'h01);
      bus_read("lvl_pending", ADDR_DATA, 8'h01);
      int_in[0] = 1'b0;
      tick();
      check("lvl_int_out_lo", {7'b0, int_out}, 8'h00);
      bus_read("lvl_pending_lo", ADDR_DATA, 8'h00);

      // Edge source 0: latched until cleared through PENDING.
      bus_write(ADDR_CMD, 8'h00);
      bus_write(ADDR_DATA, 8'h01);
      int_in[0] = 1'b1;
      tick();
      int_in[0] = 1'b0;
      tick();
      check("edge_latched", {7'b0, int_out}, 8'h01);
      bus_write(ADDR_CMD, 8'h60);
      bus_read("edge_id", ADDR_DATA, 8'h00);
      bus_write(ADDR_CMD, 8'h40);
      bus_read("edge_pending", ADDR_DATA, 8'h01);
      bus_write(ADDR_DATA, 8'h01);
      check("edge_cleared", {7'b0, int_out}, 8'h00);
      bus_read("edge_pending_clr", ADDR_DATA, 8'h00);

      // Sources 3 and 200 (edge): priority and EOI.
      bus_write(ADDR_CMD, 8'h00);
      bus_write(ADDR_DATA, 8'h09);
      bus_write(ADDR_CMD, 8'h19);
      bus_write(ADDR_DATA, 8'h01);
      bus_write(ADDR_CMD, 8'h39);
      bus_write(ADDR_DATA, 8'h01);
      int_in[3]   = 1'b1;
      int_in[200] = 1'b1;
      tick();
      int_in[3]   = 1'b0;
      int_in[200] = 1'b0;
      tick();
      bus_write(ADDR_CMD, 8'h60);
      bus_read("prio_id3", ADDR_DATA, 8'h03);
      bus_write(ADDR_CMD, 8'h80);
      bus_read("eoi_read", ADDR_DATA, 8'h00);
      bus_write(ADDR_DATA, 8'h00);
      bus_write(ADDR_CMD, 8'h60);
      bus_read("prio_id200", ADDR_DATA, 8'hC8);
      check("eoi1_int_out", {7'b0, int_out}, 8'h01);
      bus_write(ADDR_CMD, 8'h80);
      bus_write(ADDR_DATA, 8'h00);
      check("eoi2_int_out", {7'b0, int_out}, 8'h00);
      bus_write(ADDR_CMD, 8'h60);
      bus_read("prio_none", ADDR_DATA, 8'h00);

      // Source 5 (edge, disabled): pending latches regardless of enable.
      bus_write(ADDR_CMD, 8'h00);
      bus_write(ADDR_DATA, 8'h29);
      bus_write(ADDR_CMD, 8'h20);
      bus_write(ADDR_DATA, 8'hDF);
      int_in[5] = 1'b1;
      tick();
      int_in[5] = 1'b0;
      tick();
      check("dis_int_out", {7'b0, int_out}, 8'h00);
      bus_write(ADDR_CMD, 8'h40);
      bus_read("dis_pending", ADDR_DATA, 8'h20);
      bus_write(ADDR_CMD, 8'h20);
      bus_write(ADDR_DATA, 8'hFF);
      check("en5_int_out", {7'b0, int_out}, 8'h01);

      // Latched bit hidden in level mode, visible again in edge mode.
      bus_write(ADDR_CMD, 8'h00);
      bus_write(ADDR_DATA, 8'h09);
      check("hide_int_out", {7'b0, int_out}, 8'h00);
      bus_write(ADDR_CMD, 8'h40);
      bus_read("hide_pending", ADDR_DATA, 8'h00);
      bus_write(ADDR_CMD, 8'h00);
      bus_write(ADDR_DATA, 8'h29);
      check("show_int_out", {7'b0, int_out}, 8'h01);

      // Set wins over a clear in the same edge.
      bus_write(ADDR_CMD, 8'h40);
      bus_write(ADDR_DATA, 8'h20);
      bus_read("clr5", ADDR_DATA, 8'h00);
      int_in[5] = 1'b1;
      bus_write(ADDR_DATA, 8'h20);
      int_in[5] = 1'b0;
      bus_read("set_wins", ADDR_DATA, 8'h20);
      check("set_wins_int_out", {7'b0, int_out}, 8'h01);

      // Reset mid-operation.
      reset = 1'b1;
      tick();
      check("midrst_int_out", {7'b0, int_out}, 8'h00);
      reset = 1'b0;
      bus_read("midrst_cmd", ADDR_CMD, 8'h00);
      bus_read("midrst_mode0", ADDR_DATA, 8'h00);
      bus_write(ADDR_CMD, 8'h20);
      bus_read("midrst_enable0", ADDR_DATA, 8'h00);
      bus_write(ADDR_CMD, 8'h40);
      bus_read("midrst_pending0", ADDR_DATA, 8'h00);
      bus_write(ADDR_CMD, 8'h19);
      bus_read("midrst_mode25", ADDR_DATA, 8'h00);
      bus_write(ADDR_CMD, 8'h60);
      bus_read("midrst_id", ADDR_DATA, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
